dram_cmd_arbiter: RTL

DRAM_CMD_ARBITER -- requirements
Module: dram_cmd_arbiter

---
 rtl/dram_cmd_arbiter.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// dram_cmd_arbiter
//   Two-requester arbiter in front of a MIG-style DRAM command/data port.
//   A three-state FSM (IDLE / GRANT0 / GRANT1) hands the command port to one
//   requester at a time, alternating with a round-robin pointer and forcing a
//   re-arbitration after MaxBurst issued commands. Writes issue with their
//   data beat in the same cycle. Every read pushes the requester ID into a
//   tag FIFO, and returning read data is routed by popping that FIFO.
//
// Ports
//   Clock, Reset_n          : clock; asynchronous active-low reset, released
//                             through an internal 2-flop synchronizer
//   Rn_Command/Address      : requester n command and address
//   Rn_CommandValid/Ready   : requester n command handshake
//   Rn_WriteData/Mask       : requester n write beat and byte mask
//   Rn_WriteDataValid/Ready : requester n write-data handshake
//   Rn_ReadData/Valid       : requester n read return (no back-pressure)
//   DRAMCommand/Address     : muxed command to the memory controller
//   DRAMCommandValid/Ready  : memory-side command handshake
//   DRAMWriteData/Mask      : muxed write beat
//   DRAMWriteDataValid/Ready: memory-side write-data handshake
//   DRAMReadData/Valid      : read return from the memory controller
//   ErrorTagUnderflow       : sticky; read data arrived with no tag queued
//   Grant                   : one-hot current grant {GRANT1, GRANT0}
// ---------------------------------------------------------------------------
module dram_cmd_arbiter #(
    parameter int unsigned DDRCWidth = 3,
    parameter int unsigned DDRAWidth = 28,
    parameter int unsigned DDRDWidth = 512,
    parameter int unsigned DDRMWidth = 64,
    parameter int unsigned TagDepth  = 32,
    parameter int unsigned MaxBurst  = 8,
    parameter logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(0),
    parameter logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(1)
) (
    input  logic                 Clock,
    input  logic                 Reset_n,

    input  logic [DDRCWidth-1:0] R0_Command,
    input  logic [DDRAWidth-1:0] R0_Address,
    input  logic                 R0_CommandValid,
    output logic                 R0_CommandReady,
    input  logic [DDRDWidth-1:0] R0_WriteData,
    input  logic [DDRMWidth-1:0] R0_WriteMask,
    input  logic                 R0_WriteDataValid,
    output logic                 R0_WriteDataReady,
    output logic [DDRDWidth-1:0] R0_ReadData,
    output logic                 R0_ReadDataValid,

    input  logic [DDRCWidth-1:0] R1_Command,
    input  logic [DDRAWidth-1:0] R1_Address,
    input  logic                 R1_CommandValid,
    output logic                 R1_CommandReady,
    input  logic [DDRDWidth-1:0] R1_WriteData,
    input  logic [DDRMWidth-1:0] R1_WriteMask,
    input  logic                 R1_WriteDataValid,
    output logic                 R1_WriteDataReady,
    output logic [DDRDWidth-1:0] R1_ReadData,
    output logic                 R1_ReadDataValid,

    output logic [DDRCWidth-1:0] DRAMCommand,
    output logic [DDRAWidth-1:0] DRAMAddress,
    output logic                 DRAMCommandValid,
    input  logic                 DRAMCommandReady,
    output logic [DDRDWidth-1:0] DRAMWriteData,
    output logic [DDRMWidth-1:0] DRAMWriteMask,
    output logic                 DRAMWriteDataValid,
    input  logic                 DRAMWriteDataReady,
    input  logic [DDRDWidth-1:0] DRAMReadData,
    input  logic                 DRAMReadDataValid,

    output logic                 ErrorTagUnderflow,
    output logic [1:0]           Grant
);

    localparam int unsigned TagAw = $clog2(TagDepth);
    localparam int unsigned PtrW  = TagAw + 1;
    localparam int unsigned CntW  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_e;

    // Reset synchronizer: assertion is immediate, release takes two edges.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [TagDepth-1:0]   tag_mem_q;
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic                  err_q;

    // Granted requester view
    logic                  gnt_any;
    logic                  gnt_id;
    logic [DDRCWidth-1:0]  g_cmd;
    logic [DDRAWidth-1:0]  g_addr;
    logic [DDRDWidth-1:0]  g_wdata;
    logic [DDRMWidth-1:0]  g_wmask;
    logic                  g_cv;
    logic                  g_wdv;
    logic                  other_valid;

    logic                  is_write;
    logic                  is_read;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_head;
    logic                  issue;
    logic                  burst_last;
    logic                  grant_end;
    logic                  push;
    logic                  pop;

    assign gnt_any     = (state_q != ST_IDLE);
    assign gnt_id      = (state_q == ST_GRANT1);
    assign g_cmd       = gnt_id ? R1_Command        : R0_Command;
    assign g_addr      = gnt_id ? R1_Address        : R0_Address;
    assign g_wdata     = gnt_id ? R1_WriteData      : R0_WriteData;
    assign g_wmask     = gnt_id ? R1_WriteMask      : R0_WriteMask;
    assign g_cv        = gnt_id ? R1_CommandValid   : R0_CommandValid;
    assign g_wdv       = gnt_id ? R1_WriteDataValid : R0_WriteDataValid;
    assign other_valid = gnt_id ? R0_CommandValid   : R1_CommandValid;

    assign is_write  = (g_cmd == CmdWrite);
    assign is_read   = (g_cmd == CmdRead);
    assign tag_empty = (wr_ptr_q == rd_ptr_q);
    assign tag_full  = (wr_ptr_q[TagAw] != rd_ptr_q[TagAw]) &&
                       (wr_ptr_q[TagAw-1:0] == rd_ptr_q[TagAw-1:0]);
    assign tag_head  = tag_mem_q[rd_ptr_q[TagAw-1:0]];

    // Issue qualifier: writes need their data beat accepted in the same
    // cycle; reads need a free tag slot; any other opcode just needs the port.
    always_comb begin
        issue = 1'b0;
        if (gnt_any && g_cv && DRAMCommandReady) begin
            if (is_write) begin
                issue = g_wdv && DRAMWriteDataReady;
            end else if (is_read) begin
                issue = !tag_full;
            end else begin
                issue = 1'b1;
            end
        end
    end

    assign burst_last = (burst_cnt_q == CntW'(MaxBurst - 1));
    assign grant_end  = gnt_any && (!g_cv || (issue && burst_last));
    assign push       = issue && is_read;
    assign pop        = DRAMReadDataValid && !tag_empty;

    // State register
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state: arbitration, burst counting, grant hand-over
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (R0_CommandValid && R1_CommandValid) begin
                    state_d = rr_q ? ST_GRANT1 : ST_GRANT0;
                end else if (R0_CommandValid) begin
                    state_d = ST_GRANT0;
                end else if (R1_CommandValid) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (grant_end) begin
                    rr_d        = !gnt_id;
                    burst_cnt_d = '0;
                    if (other_valid) begin
                        state_d = gnt_id ? ST_GRANT0 : ST_GRANT1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (issue) begin
                    burst_cnt_d = burst_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Outputs: DRAM-side mux and requester handshakes, all zero in IDLE.
    // Write-data ready is only raised for a write issue so a pending write
    // beat is never swallowed by a read or other command.
    always_comb begin
        DRAMCommand        = '0;
        DRAMAddress        = '0;
        DRAMWriteData      = '0;
        DRAMWriteMask      = '0;
        DRAMCommandValid   = 1'b0;
        DRAMWriteDataValid = 1'b0;
        R0_CommandReady    = 1'b0;
        R1_CommandReady    = 1'b0;
        R0_WriteDataReady  = 1'b0;
        R1_WriteDataReady  = 1'b0;
        Grant              = 2'b00;
        if (gnt_any) begin
            DRAMCommand        = g_cmd;
            DRAMAddress        = g_addr;
            DRAMWriteData      = g_wdata;
            DRAMWriteMask      = g_wmask;
            DRAMCommandValid   = issue;
            DRAMWriteDataValid = issue && is_write;
            R0_CommandReady    = issue && !gnt_id;
            R1_CommandReady    = issue && gnt_id;
            R0_WriteDataReady  = issue && is_write && !gnt_id;
            R1_WriteDataReady  = issue && is_write && gnt_id;
            Grant              = {gnt_id, !gnt_id};
        end
    end

    // Tag FIFO of requester IDs for outstanding reads, plus underflow flag
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            tag_mem_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                tag_mem_q[wr_ptr_q[TagAw-1:0]] <= gnt_id;
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (DRAMReadDataValid && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Read return: data fans out to both, valid follows the FIFO head
    assign R0_ReadData       = DRAMReadData;
    assign R1_ReadData       = DRAMReadData;
    assign R0_ReadDataValid  = pop && !tag_head;
    assign R1_ReadDataValid  = pop && tag_head;
    assign ErrorTagUnderflow = err_q;

endmodule
